// File: rtl/count_reader.sv
// count_reader: initiator for the counter readback interface.
// A start pulse sweeps idx 0..NUM_CH-1; each request is held until the
// counter block answers with valid (count latched) or the per-channel
// timeout expires (count forced to 0 and the channel flagged in err_mask).
module count_reader #(
   parameter int NUM_CH  = 5,
   parameter int DATA_W  = 5,
   parameter int TIMEOUT = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       valid,
   input  logic [DATA_W-1:0]          data_out,
   output logic [2:0]                 idx,
   output logic                       req,
   output logic [NUM_CH*DATA_W-1:0]   counts,
   output logic [NUM_CH-1:0]          err_mask,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 o_dbg_state
);

   // Handshake: while req is high idx is stable; the responder asserts valid
   // when data_out holds the count for idx. A request completes on the first
   // rising edge where req and valid are both high. valid with req low is
   // ignored, so a responder may leave valid high between requests.

   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [2:0]       LAST_IDX = 3'(NUM_CH - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [2:0]                 r_idx;
   logic [TMO_W-1:0]           r_tmo;
   logic [NUM_CH*DATA_W-1:0]   r_counts;
   logic [NUM_CH-1:0]          r_err;
   logic                       r_req;
   logic                       r_busy;
   logic                       r_done;
   logic                       w_capture;
   logic                       w_timeout;

   // Next-state decode; capture/timeout are the two ways a request finishes.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_REQ;
         end
         S_REQ: begin
            if (valid) begin
               w_capture = 1'b1;
               w_next    = (r_idx == LAST_IDX) ? S_DONE : S_GAP;
            end else if (r_tmo == TMO_LAST) begin
               w_timeout = 1'b1;
               w_next    = (r_idx == LAST_IDX) ? S_DONE : S_GAP;
            end
         end
         S_GAP:   w_next = S_REQ;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register plus registered status outputs decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_req   <= (w_next == S_REQ);
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
      end
   end

   // Sweep datapath: channel index, per-request timeout counter, results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx    <= 3'd0;
         r_tmo    <= '0;
         r_counts <= '0;
         r_err    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx    <= 3'd0;
                  r_tmo    <= '0;
                  r_counts <= '0;
                  r_err    <= '0;
               end
            end
            S_REQ: begin
               if (w_capture || w_timeout) begin
                  r_tmo <= '0;
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (r_idx == 3'(k)) begin
                        r_counts[k*DATA_W +: DATA_W] <= w_capture ? data_out : '0;
                        if (w_timeout) r_err[k] <= 1'b1;
                     end
                  end
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_GAP: begin
               r_idx <= r_idx + 3'd1;
               r_tmo <= '0;
            end
            S_DONE: begin
               r_idx <= 3'd0;
            end
            default: ;
         endcase
      end
   end

   assign idx         = r_idx;
   assign req         = r_req;
   assign counts      = r_counts;
   assign err_mask    = r_err;
   assign busy        = r_busy;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_count_reader.sv
// Directed bench for count_reader with a modelled counter-block responder.
module tb_count_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        valid;
   logic [4:0]  data_out;
   logic [2:0]  idx;
   logic        req;
   logic [24:0] counts;
   logic [4:0]  err_mask;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   // responder controls
   logic        zero_mode;
   logic        force_valid;
   logic        resp_valid;
   logic [2:0]  silent_ch;
   logic [4:0]  tbl [8];
   logic        p_req;
   logic        p_v;
   logic [2:0]  p_idx;

   // scoreboard
   logic [24:0] exp_q [$];
   logic [4:0]  err_q [$];
   int          total = 0;
   int          bad   = 0;

   count_reader #(.NUM_CH(5), .DATA_W(5), .TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .valid       (valid),
      .data_out    (data_out),
      .idx         (idx),
      .req         (req),
      .counts      (counts),
      .err_mask    (err_mask),
      .busy        (busy),
      .done        (done),
      .o_dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // responder inputs: forced pulse overrides, zero-latency ties valid high
   always_comb begin
      valid    = force_valid | (zero_mode ? 1'b1 : resp_valid);
      data_out = 5'd0;
      if (force_valid)    data_out = 5'd9;
      else if (zero_mode) data_out = 5'(idx + 3'd1);
      else                data_out = tbl[idx];
   end

   // one-cycle-latency responder: answers the cycle after it sees req,
   // stays silent for silent_ch
   always begin
      @(posedge clk);
      p_req = req;
      p_v   = resp_valid;
      p_idx = idx;
      #1;
      resp_valid = p_req && !p_v && (p_idx != silent_ch);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   {31'd0, req},       32'd0);
      chk({tag, "_idx"},   {29'd0, idx},       32'd0);
      chk({tag, "_busy"},  {31'd0, busy},      32'd0);
      chk({tag, "_done"},  {31'd0, done},      32'd0);
      chk({tag, "_cnt"},   {7'd0, counts},     32'd0);
      chk({tag, "_err"},   {27'd0, err_mask},  32'd0);
      chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
   endtask

   // Drive one start pulse, follow the sweep, compare against the scoreboard.
   task automatic run_sweep(input string tag, input int exp_done_n,
                            input int exp_req_n, input bit abuse);
      int n;
      int rq;
      logic [24:0] ec;
      logic [4:0]  ee;
      n  = 0;
      rq = 0;
      @(negedge clk);
      start = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            start = 1'b0;
            chk({tag, "_clr_cnt"}, {7'd0, counts},    32'd0);
            chk({tag, "_clr_err"}, {27'd0, err_mask}, 32'd0);
         end
         if (abuse && n == 3) force_valid = 1'b1;
         if (abuse && n == 4) force_valid = 1'b0;
         if (abuse && n == 5) start = 1'b1;
         if (abuse && n == 6) start = 1'b0;
         if (req) rq++;
      end while (!done && n < 200);
      chk({tag, "_done_cyc"}, n,  exp_done_n);
      chk({tag, "_req_cyc"},  rq, exp_req_n);
      chk({tag, "_busy_dn"},  {31'd0, busy}, 32'd1);
      ec = exp_q.pop_front();
      ee = err_q.pop_front();
      chk({tag, "_counts"}, {7'd0, counts},    {7'd0, ec});
      chk({tag, "_err"},    {27'd0, err_mask}, {27'd0, ee});
      @(posedge clk);
      #1;
      chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle"},      {31'd0, busy}, 32'd0);
      chk({tag, "_idx0"},      {29'd0, idx},  32'd0);
      chk({tag, "_hold"},      {7'd0, counts}, {7'd0, ec});
   endtask

   initial begin
      int n;
      tbl[0] = 5'd3;  tbl[1] = 5'd0; tbl[2] = 5'd31; tbl[3] = 5'd7;
      tbl[4] = 5'd12; tbl[5] = 5'd0; tbl[6] = 5'd0;  tbl[7] = 5'd0;
      reset       = 1'b0;
      start       = 1'b0;
      zero_mode   = 1'b0;
      force_valid = 1'b0;
      resp_valid  = 1'b0;
      silent_ch   = 3'd7;

      // async reset before any clock edge
      #3 reset = 1'b1;
      #1 chk_reset_vals("rst_async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // full sweep, 1-cycle responder
      exp_q.push_back({5'd12, 5'd7, 5'd31, 5'd0, 5'd3});
      err_q.push_back(5'b00000);
      run_sweep("full", 15, 10, 1'b0);

      // timeout on channel 2
      silent_ch = 3'd2;
      exp_q.push_back({5'd12, 5'd7, 5'd0, 5'd0, 5'd3});
      err_q.push_back(5'b00100);
      run_sweep("tmo", 21, 16, 1'b0);
      silent_ch = 3'd7;

      // zero latency responder
      zero_mode = 1'b1;
      exp_q.push_back({5'd5, 5'd4, 5'd3, 5'd2, 5'd1});
      err_q.push_back(5'b00000);
      run_sweep("zero", 10, 5, 1'b0);
      zero_mode = 1'b0;

      // protocol abuse: start while busy, valid during GAP
      exp_q.push_back({5'd12, 5'd7, 5'd31, 5'd0, 5'd3});
      err_q.push_back(5'b00000);
      run_sweep("abuse", 15, 10, 1'b1);

      // valid with req low in IDLE must not capture or start anything
      @(negedge clk);
      force_valid = 1'b1;
      repeat (3) @(negedge clk);
      force_valid = 1'b0;
      chk("idle_valid_cnt",  {7'd0, counts}, {7'd0, 25'({5'd12, 5'd7, 5'd31, 5'd0, 5'd3})});
      chk("idle_valid_busy", {31'd0, busy}, 32'd0);
      chk("idle_valid_req",  {31'd0, req},  32'd0);

      // reset during the idx 3 request
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(req && idx == 3'd3) && n < 100);
      chk("reach_idx3", {31'd0, (req && idx == 3'd3)}, 32'd1);
      #2 reset = 1'b1;
      #1 chk_reset_vals("rst_mid");
      n = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) n++;
      end
      chk("rst_no_done", n, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // fresh sweep after the interrupted one
      exp_q.push_back({5'd12, 5'd7, 5'd31, 5'd0, 5'd3});
      err_q.push_back(5'b00000);
      run_sweep("after_rst", 15, 10, 1'b0);

      chk("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
